// File: rtl/spi_slave_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_slave_sync: SPI slave oversampled in the clk domain, valid/ready RX/TX  |
// | Option macro: SPI_SLAVE_SYNC_RX_FIFO_EN (DEPTH-entry RX FIFO)               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module spi_slave_sync #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             nCS,
  input  logic             SCK,
  input  logic             MOSI,
  output logic             MISO,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             busy,
  output logic             rx_overflow,
  output logic             tx_underrun
);

  localparam int CNT_W       = $clog2(WIDTH);
  localparam bit SAMPLE_RISE = (CPOL == CPHA);

  generate
    if (DEPTH < 2 || WIDTH < 4 || SYNC_STAGES < 2) begin : g_param_guard
    end
  endgenerate

  logic [SYNC_STAGES-1:0] ncs_sync, sck_sync, mosi_sync;
  logic ncs_s, sck_s, mosi_s, ncs_d, sck_d, sample_p, shift_p;

  assign ncs_s  = ncs_sync[SYNC_STAGES-1];
  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ncs_sync  <= '1;
      sck_sync  <= {SYNC_STAGES{CPOL}};
      mosi_sync <= '0;
      ncs_d     <= 1'b1;
      sck_d     <= CPOL;
      sample_p  <= 1'b0;
      shift_p   <= 1'b0;
    end else begin
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], nCS};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      ncs_d     <= ncs_s;
      sck_d     <= sck_s;
      sample_p  <= ~ncs_s & (SAMPLE_RISE ? (sck_s & ~sck_d) : (~sck_s & sck_d));
      shift_p   <= ~ncs_s & (SAMPLE_RISE ? (~sck_s & sck_d) : (sck_s & ~sck_d));
    end
  end

  logic             frame_start, frame_end, do_sample, do_shift, fetch, push, pop, bit_last;
  logic             sampled, pending, hold_valid;
  logic [CNT_W-1:0] bitcnt;
  logic [WIDTH-1:0] rx_shift, tx_shift, tx_shift_nx, hold, fetch_word, push_word;

  assign frame_start = ncs_d & ~ncs_s;
  assign frame_end   = ~ncs_d & ncs_s;
  assign do_sample   = sample_p & ~ncs_s;
  assign do_shift    = shift_p & ~ncs_s;
  assign bit_last    = (bitcnt == CNT_W'(WIDTH - 1));
  // In CPHA=0 the word is fetched at frame start, so a bitcnt==0 shift edge
  // before any sample must not fetch a second one.
  assign fetch       = (!CPHA && frame_start) ||
                       (do_shift && (bitcnt == '0) && (CPHA || sampled));
  assign tx_ready    = fetch & ~hold_valid & tx_valid;
  assign tx_underrun = fetch & ~hold_valid & ~tx_valid;
  assign fetch_word  = hold_valid ? hold : (tx_valid ? tx_data : '1);
  assign push        = do_sample & bit_last;
  assign push_word   = {rx_shift[WIDTH-2:0], mosi_s};
  assign pop         = rx_valid & rx_ready;
  assign busy        = ~ncs_s;

  always_comb begin
    tx_shift_nx = tx_shift;
    if (fetch) begin
      tx_shift_nx = fetch_word;
    end else if (do_shift) begin
      tx_shift_nx = {tx_shift[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bitcnt     <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      sampled    <= 1'b0;
      pending    <= 1'b0;
      MISO       <= 1'b0;
    end else begin
      tx_shift <= tx_shift_nx;
      MISO     <= ~ncs_s & tx_shift_nx[WIDTH-1];
      if (frame_start || frame_end) begin
        bitcnt <= '0;
      end else if (do_sample) begin
        bitcnt <= bit_last ? '0 : bitcnt + 1'b1;
      end
      if (do_sample) begin
        rx_shift <= push_word;
      end
      if (frame_start) begin
        sampled <= 1'b0;
      end else if (do_sample) begin
        sampled <= 1'b1;
      end
      // A real word fetched but never clocked out is kept for the next frame.
      if (fetch) begin
        pending <= hold_valid | tx_valid;
      end else if (do_sample || frame_end) begin
        pending <= 1'b0;
      end
      if (frame_end && pending) begin
        hold       <= tx_shift;
        hold_valid <= 1'b1;
      end else if (fetch) begin
        hold_valid <= 1'b0;
      end
    end
  end

`ifdef SPI_SLAVE_SYNC_RX_FIFO_EN
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, accept;

  assign full        = (count == (AW+1)'(DEPTH));
  assign accept      = push & (~full | pop);
  assign rx_overflow = push & full & ~pop;
  assign rx_valid    = (count != '0);
  assign rx_data     = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (accept && !pop) begin
        count <= count + 1'b1;
      end else if (!accept && pop) begin
        count <= count - 1'b1;
      end
    end
  end
`else
  assign rx_overflow = push & rx_valid & ~rx_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (push && (!rx_valid || rx_ready)) begin
      rx_data  <= push_word;
      rx_valid <= 1'b1;
    end else if (pop) begin
      rx_valid <= 1'b0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/spi_slave_sync.md
# spi_slave_sync

Oversampled, parametrised SPI slave that runs entirely in the internal `clk` domain. It synchronises the SPI pins `nCS`, `SCK` and `MOSI` into `clk` and detects SCK edges there. Word width and SPI mode (CPOL/CPHA) are set by parameters. Received words leave through a valid/ready stream, optionally buffered; transmit words enter through a valid/ready stream. It replaces the SCK-clocked slave on the host-side control link of the ULPI gateway.

## Interface
- `WIDTH`, 8: bits per SPI word, MSB first; legal values 4..32.
- `DEPTH`, 4: RX FIFO entries, power of two, at least 2. Used only with `SPI_SLAVE_SYNC_RX_FIFO_EN`.
- `CPOL`, 0: SCK idle level.
- `CPHA`, 0: 0 means sample on the leading edge; 1 means sample on the trailing edge.
- `SYNC_STAGES`, 2: synchroniser flops per pin input; at least 2.
- `clk`  in  1  internal clock.
- `reset`  in  1  asynchronous, active-high.
- `nCS`  in  1  chip select, active-low, asynchronous to `clk`.
- `SCK`  in  1  SPI clock, asynchronous to `clk`.
- `MOSI`  in  1  serial data in.
- `MISO`  out  1  serial data out, registered; tristating is done outside this block.
- `rx_data`  out  WIDTH  received word.
- `rx_valid`  out  1  `rx_data` is valid.
- `rx_ready`  in  1  consumer accepts `rx_data`.
- `tx_data`  in  WIDTH  next word to shift out.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  one-cycle pulse; the word is taken when `tx_valid` and `tx_ready` are both high.
- `busy`  out  1  synchronised `nCS` is low.
- `rx_overflow`  out  1  one-cycle pulse; a completed word was dropped.
- `tx_underrun`  out  1  one-cycle pulse; the block fetched a word while `tx_valid` was low.

## Operation
- **Synchronisers.** Each pin passes through `SYNC_STAGES` flops. On reset they load idle values: `nCS` = 1, `SCK` = CPOL, `MOSI` = 0.
- **Edge detection.** A further register on synchronised `SCK` produces edge pulses.
  - sample edge = rising edge when `CPOL == CPHA`, otherwise falling edge.
  - shift edge = the opposite edge.
  - SCK edges are ignored while synchronised `nCS` is high.
- **Frame start.** Synchronised `nCS` falls:
  - `bitcnt` is cleared.
  - If `CPHA == 0`, a fetch happens in the same cycle.
- **Sample edge.**
  - `rx_shift <= {rx_shift[WIDTH-2:0], MOSI_sync}`.
  - `bitcnt` increments and wraps from WIDTH-1 to 0.
  - On the wrap the word is complete and is pushed to RX.
- **Shift edge.**
  - If `bitcnt == 0` (and, for CPHA=0, at least one sample has occurred in the frame), fetch.
  - Otherwise `tx_shift` shifts left.
  - `MISO = tx_shift[WIDTH-1]` whenever synchronised `nCS` is low. `MISO` is 0 when `nCS` is high.
- **Fetch.** The first source that applies is used:
  1. A word held in `tx_hold` is loaded.
  2. Otherwise, if `tx_valid`, `tx_data` is loaded and `tx_ready` pulses.
  3. Otherwise all-ones is loaded and `tx_underrun` pulses.
- **End of frame.** Synchronised `nCS` rises:
  - Partial RX bits are discarded; `bitcnt` is cleared.
  - If the last fetch loaded a word but no sample edge followed it (CPHA=0 trailing fetch), that word moves to `tx_hold` and is sent first in the next frame. No tx word is ever lost.
- **RX push when full.** If RX is full at a push, the new word is dropped and `rx_overflow` pulses. Stored data is unchanged.
- **Simultaneous events.** If an RX push and an `rx_valid && rx_ready` pop occur in the same cycle, both take effect. A full FIFO with a pop in that cycle does not overflow.
- **Reset.** Asserting `reset` mid-frame aborts the frame. All outputs go to 0: `MISO`, `rx_data`, `rx_valid`, `tx_ready`, `busy`, `rx_overflow`, `tx_underrun`. `tx_hold` and the RX storage are cleared.

## Timing
- `clk` must be at least 4× the SCK frequency, and SCK high and low times must each be at least 2 `clk` periods.
- Edge pulse: asserted `SYNC_STAGES+1` clk cycles after the pin edge.
- `MISO` update: at clk edge `SYNC_STAGES+2` after the SCK shift edge on the pin.
- `rx_valid`: asserts `SYNC_STAGES+2` clk cycles after the final sample edge on the pin (empty RX).
- `tx_ready`: a single-cycle pulse in the fetch cycle. `tx_data` is sampled only in that cycle.
- `busy`: follows pin `nCS` with `SYNC_STAGES` cycles of latency.

## Configuration
- `SPI_SLAVE_SYNC_RX_FIFO_EN` defined:
  - RX is a `DEPTH`-entry FIFO with show-ahead output.
  - `rx_valid` = not empty.
  - Overflow only when all `DEPTH` entries are occupied.
- `SPI_SLAVE_SYNC_RX_FIFO_EN` undefined:
  - RX is a single holding register; `DEPTH` is ignored.
  - Overflow when a word completes while `rx_valid && !rx_ready`.

## Test plan
- **Mode 0, WIDTH=8.** Master sends 0xA5 with `tx_data`=0x3C and `tx_valid` high before `nCS` falls -> `rx_data`=0xA5 with a one-cycle `rx_valid` handshake; master receives 0x3C; exactly one `tx_ready` pulse.
- **Each mode, CPOL/CPHA ∈ {00, 01, 10, 11}, WIDTH=16.** Master sends 0x1234, block returns 0xBEEF -> both sides match in all four modes.
- **Underrun then hold.** `tx_valid` low at fetch -> master receives 0xFF and `tx_underrun` pulses once. In CPHA=0 a 2-word frame with the trailing fetch of 0x55, then `nCS` rises -> the next frame's first MISO word is 0x55.
- **Overflow.** `rx_ready` held low, 5 words sent with the FIFO enabled and DEPTH=4 -> words 1–4 retained in order, word 5 dropped, one `rx_overflow` pulse. With the FIFO disabled -> word 1 retained, words 2–5 dropped, four pulses.
- **Abort.** `nCS` rises after 5 bits -> no `rx_valid` and `bitcnt` reset. Next full frame 0x81 -> `rx_data`=0x81.
- **Reset mid-frame.** `reset` asserted after 3 bits -> all outputs 0 within the same cycle. After release, a new frame 0x42 -> received correctly.
